axi_lite_master_interface: RTL and testbench

- AXI-Lite initiator (master) that converts simple single-beat user read and write requests into AXI-Lite transactions.
- Sits between a local controller (CPU/DMA glue) and the interconnect; drives AW/W/AR and sinks B/R toward an axi_lite_slave_interface.
- Write and read paths are independent FSMs and may run concurrently.
- One outstanding transaction per direction.

---
 rtl/axi_lite_master_interface.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_lite_master_interface.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_interface.sv
// AXI-Lite initiator: turns single-beat local read/write requests into AXI-Lite transactions.
// Write (AW/W/B) and read (AR/R) run as independent FSMs, one outstanding transfer each.
module axi_lite_master_interface #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TRANS_W_STRB_W  = 4,
  parameter int unsigned TRANS_WR_RESP_W = 2,
  parameter int unsigned TRANS_PROT      = 3
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  // local write port
  input  logic                       i_wr_req,
  input  logic [ADDR_WIDTH-1:0]      i_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic [TRANS_W_STRB_W-1:0]  i_wr_strb,
  input  logic [TRANS_PROT-1:0]      i_wr_prot,
  output logic                       o_wr_ready,
  output logic                       o_wr_done,
  output logic [TRANS_WR_RESP_W-1:0] o_wr_resp,
  // local read port
  input  logic                       i_rd_req,
  input  logic [ADDR_WIDTH-1:0]      i_rd_addr,
  input  logic [TRANS_PROT-1:0]      i_rd_prot,
  output logic                       o_rd_ready,
  output logic                       o_rd_done,
  output logic [DATA_WIDTH-1:0]      o_rd_data,
  output logic [TRANS_WR_RESP_W-1:0] o_rd_resp,
  // AXI-Lite write channels
  output logic [ADDR_WIDTH-1:0]      o_axi_awaddr,
  output logic [TRANS_PROT-1:0]      o_axi_awprot,
  output logic                       o_axi_awvalid,
  input  logic                       i_axi_awready,
  output logic [DATA_WIDTH-1:0]      o_axi_wdata,
  output logic [TRANS_W_STRB_W-1:0]  o_axi_wstrb,
  output logic                       o_axi_wvalid,
  input  logic                       i_axi_wready,
  input  logic [TRANS_WR_RESP_W-1:0] i_axi_bresp,
  input  logic                       i_axi_bvalid,
  output logic                       o_axi_bready,
  // AXI-Lite read channels
  output logic [ADDR_WIDTH-1:0]      o_axi_araddr,
  output logic [TRANS_PROT-1:0]      o_axi_arprot,
  output logic                       o_axi_arvalid,
  input  logic                       i_axi_arready,
  input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
  input  logic [TRANS_WR_RESP_W-1:0] i_axi_rresp,
  input  logic                       i_axi_rvalid,
  output logic                       o_axi_rready
);

  typedef enum logic [1:0] {WIdle, WAddrData, WResp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;

  wr_state_e                  r_wr_state, w_wr_state_d;
  logic [ADDR_WIDTH-1:0]      r_awaddr, w_awaddr_d;
  logic [TRANS_PROT-1:0]      r_awprot, w_awprot_d;
  logic                       r_awvalid, w_awvalid_d;
  logic [DATA_WIDTH-1:0]      r_wdata, w_wdata_d;
  logic [TRANS_W_STRB_W-1:0]  r_wstrb, w_wstrb_d;
  logic                       r_wvalid, w_wvalid_d;
  logic                       r_bready, w_bready_d;
  logic                       r_wr_ready, w_wr_ready_d;
  logic                       r_wr_done, w_wr_done_d;
  logic [TRANS_WR_RESP_W-1:0] r_wr_resp, w_wr_resp_d;

  rd_state_e                  r_rd_state, w_rd_state_d;
  logic [ADDR_WIDTH-1:0]      r_araddr, w_araddr_d;
  logic [TRANS_PROT-1:0]      r_arprot, w_arprot_d;
  logic                       r_arvalid, w_arvalid_d;
  logic                       r_rready, w_rready_d;
  logic                       r_rd_ready, w_rd_ready_d;
  logic                       r_rd_done, w_rd_done_d;
  logic [DATA_WIDTH-1:0]      r_rd_data, w_rd_data_d;
  logic [TRANS_WR_RESP_W-1:0] r_rd_resp, w_rd_resp_d;

  always_comb begin
    w_wr_state_d = r_wr_state;
    w_awaddr_d   = r_awaddr;
    w_awprot_d   = r_awprot;
    w_awvalid_d  = r_awvalid;
    w_wdata_d    = r_wdata;
    w_wstrb_d    = r_wstrb;
    w_wvalid_d   = r_wvalid;
    w_bready_d   = r_bready;
    w_wr_ready_d = r_wr_ready;
    w_wr_done_d  = 1'b0;
    w_wr_resp_d  = r_wr_resp;
    unique case (r_wr_state)
      WIdle: begin
        if (i_wr_req && r_wr_ready) begin
          w_awaddr_d   = i_wr_addr;
          w_awprot_d   = i_wr_prot;
          w_wdata_d    = i_wr_data;
          w_wstrb_d    = i_wr_strb;
          w_awvalid_d  = 1'b1;
          w_wvalid_d   = 1'b1;
          w_wr_ready_d = 1'b0;
          w_wr_state_d = WAddrData;
        end
      end
      WAddrData: begin
        // A dropped valid marks its channel as already transferred.
        if (r_awvalid && i_axi_awready) w_awvalid_d = 1'b0;
        if (r_wvalid && i_axi_wready) w_wvalid_d = 1'b0;
        if (!w_awvalid_d && !w_wvalid_d) begin
          w_bready_d   = 1'b1;
          w_wr_state_d = WResp;
        end
      end
      WResp: begin
        if (i_axi_bvalid) begin
          w_wr_resp_d  = i_axi_bresp;
          w_bready_d   = 1'b0;
          w_wr_done_d  = 1'b1;
          w_wr_ready_d = 1'b1;
          w_wr_state_d = WIdle;
        end
      end
      default: w_wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    w_rd_state_d = r_rd_state;
    w_araddr_d   = r_araddr;
    w_arprot_d   = r_arprot;
    w_arvalid_d  = r_arvalid;
    w_rready_d   = r_rready;
    w_rd_ready_d = r_rd_ready;
    w_rd_done_d  = 1'b0;
    w_rd_data_d  = r_rd_data;
    w_rd_resp_d  = r_rd_resp;
    unique case (r_rd_state)
      RIdle: begin
        if (i_rd_req && r_rd_ready) begin
          w_araddr_d   = i_rd_addr;
          w_arprot_d   = i_rd_prot;
          w_arvalid_d  = 1'b1;
          w_rd_ready_d = 1'b0;
          w_rd_state_d = RAddr;
        end
      end
      RAddr: begin
        if (i_axi_arready) begin
          w_arvalid_d  = 1'b0;
          w_rready_d   = 1'b1;
          w_rd_state_d = RData;
        end
      end
      RData: begin
        if (i_axi_rvalid) begin
          w_rd_data_d  = i_axi_rdata;
          w_rd_resp_d  = i_axi_rresp;
          w_rready_d   = 1'b0;
          w_rd_done_d  = 1'b1;
          w_rd_ready_d = 1'b1;
          w_rd_state_d = RIdle;
        end
      end
      default: w_rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wr_state <= WIdle;
      r_awaddr   <= '0;
      r_awprot   <= '0;
      r_awvalid  <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_wr_ready <= 1'b1;
      r_wr_done  <= 1'b0;
      r_wr_resp  <= '0;
      r_rd_state <= RIdle;
      r_araddr   <= '0;
      r_arprot   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rd_ready <= 1'b1;
      r_rd_done  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_resp  <= '0;
    end else begin
      r_wr_state <= w_wr_state_d;
      r_awaddr   <= w_awaddr_d;
      r_awprot   <= w_awprot_d;
      r_awvalid  <= w_awvalid_d;
      r_wdata    <= w_wdata_d;
      r_wstrb    <= w_wstrb_d;
      r_wvalid   <= w_wvalid_d;
      r_bready   <= w_bready_d;
      r_wr_ready <= w_wr_ready_d;
      r_wr_done  <= w_wr_done_d;
      r_wr_resp  <= w_wr_resp_d;
      r_rd_state <= w_rd_state_d;
      r_araddr   <= w_araddr_d;
      r_arprot   <= w_arprot_d;
      r_arvalid  <= w_arvalid_d;
      r_rready   <= w_rready_d;
      r_rd_ready <= w_rd_ready_d;
      r_rd_done  <= w_rd_done_d;
      r_rd_data  <= w_rd_data_d;
      r_rd_resp  <= w_rd_resp_d;
    end
  end

  assign o_wr_ready    = r_wr_ready;
  assign o_wr_done     = r_wr_done;
  assign o_wr_resp     = r_wr_resp;
  assign o_rd_ready    = r_rd_ready;
  assign o_rd_done     = r_rd_done;
  assign o_rd_data     = r_rd_data;
  assign o_rd_resp     = r_rd_resp;
  assign o_axi_awaddr  = r_awaddr;
  assign o_axi_awprot  = r_awprot;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = r_wstrb;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_bready  = r_bready;
  assign o_axi_araddr  = r_araddr;
  assign o_axi_arprot  = r_arprot;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_interface.sv
// Bench for axi_lite_master_interface: configurable-latency slave model, expectation queues
// filled at request time and drained by channel/done monitors.
module tb_axi_lite_master_interface;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic [3:0]  wr_strb = '0;
  logic [2:0]  wr_prot = '0, rd_prot = '0;
  logic        wr_ready, wr_done, rd_ready, rd_done;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  axi_lite_master_interface dut (
    .clk_i(clk), .resetn_i(resetn),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
    .i_wr_prot(wr_prot), .o_wr_ready(wr_ready), .o_wr_done(wr_done), .o_wr_resp(wr_resp),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_prot(rd_prot), .o_rd_ready(rd_ready),
    .o_rd_done(rd_done), .o_rd_data(rd_data), .o_rd_resp(rd_resp),
    .o_axi_awaddr(awaddr), .o_axi_awprot(awprot), .o_axi_awvalid(awvalid),
    .i_axi_awready(awready), .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wvalid(wvalid),
    .i_axi_wready(wready), .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .o_axi_araddr(araddr), .o_axi_arprot(arprot), .o_axi_arvalid(arvalid),
    .i_axi_arready(arready), .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid),
    .o_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an unexpected transfer, required none", name);
  endtask

  logic [34:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [1:0]  exp_b[$];
  logic [34:0] exp_ar[$];
  logic [33:0] exp_r[$];

  int          cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  logic [31:0] cfg_rdata = '0;
  bit          stray = 1'b0;

  // Slave model: ready/valid decided at negedge, so a flagged handshake lands on the next posedge.
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hs_cnt = 0;
  bit aw_got, w_got, b_pend, b_hs, ar_got, r_pend, r_hs;

  always @(negedge clk) begin
    if (!resetn) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; ar_got = 0; r_pend = 0; r_hs = 0;
    end else begin
      if (b_hs) begin bvalid = 0; b_pend = 0; b_hs = 0; end
      if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
      if (b_pend && !bvalid) begin
        if (b_cnt >= cfg_b_d) begin bvalid = 1; bresp = cfg_bresp; end
        b_cnt++;
      end else if (!b_pend) begin
        bvalid = stray; bresp = 2'b11;
      end
      if (bvalid && bready) b_hs = 1;

      if (awvalid) begin
        awready = (aw_cnt >= cfg_aw_d);
        aw_cnt++;
        if (awready) begin
          aw_got = 1; aw_hs_cnt++;
          if (exp_aw.size() == 0) unexpected("aw_handshake");
          else chk("aw_payload", {awaddr, awprot}, exp_aw.pop_front());
        end
      end else begin awready = 0; aw_cnt = 0; end

      if (wvalid) begin
        wready = (w_cnt >= cfg_w_d);
        w_cnt++;
        if (wready) begin
          w_got = 1;
          if (exp_w.size() == 0) unexpected("w_handshake");
          else chk("w_payload", {wdata, wstrb}, exp_w.pop_front());
        end
      end else begin wready = 0; w_cnt = 0; end

      if (r_hs) begin rvalid = 0; r_pend = 0; r_hs = 0; end
      if (ar_got) begin r_pend = 1; r_cnt = 0; ar_got = 0; end
      if (r_pend && !rvalid) begin
        if (r_cnt >= cfg_r_d) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; end
        r_cnt++;
      end else if (!r_pend) begin
        rvalid = stray; rdata = 32'hBAD0_BAD0; rresp = 2'b11;
      end
      if (rvalid && rready) r_hs = 1;

      if (arvalid) begin
        arready = (ar_cnt >= cfg_ar_d);
        ar_cnt++;
        if (arready) begin
          ar_got = 1;
          if (exp_ar.size() == 0) unexpected("ar_handshake");
          else chk("ar_payload", {araddr, arprot}, exp_ar.pop_front());
        end
      end else begin arready = 0; ar_cnt = 0; end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (wr_done) begin
        if (exp_b.size() == 0) unexpected("wr_done");
        else chk("wr_resp", wr_resp, exp_b.pop_front());
      end
      if (rd_done) begin
        if (exp_r.size() == 0) unexpected("rd_done");
        else chk("rd_data_resp", {rd_data, rd_resp}, exp_r.pop_front());
      end
    end
  end

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input logic [1:0] resp, input bit accept);
    wr_req = 1; wr_addr = a; wr_data = d; wr_strb = s; wr_prot = p;
    chk("wr_ready_at_req", wr_ready, accept);
    if (accept) begin
      exp_aw.push_back({a, p});
      exp_w.push_back({d, s});
      exp_b.push_back(resp);
    end
  endtask

  task automatic drive_rd(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d,
                          input logic [1:0] resp, input bit accept);
    rd_req = 1; rd_addr = a; rd_prot = p;
    chk("rd_ready_at_req", rd_ready, accept);
    if (accept) begin
      exp_ar.push_back({a, p});
      exp_r.push_back({d, resp});
    end
  endtask

  // Called at a negedge; n counts cycles since the request edge.
  task automatic wait_wr(input int start, output int n);
    n = start;
    while (wr_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (wr_done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_done_timeout: got no done, required done within 200 cycles");
    end
  endtask

  task automatic wait_rd(input int start, output int n);
    n = start;
    while (rd_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (rd_done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL rd_done_timeout: got no done, required done within 200 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  int n, nw, nr, base;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    chk("rst_readies", {bready, rready}, 2'b00);
    chk("rst_done", {wr_done, rd_done}, 2'b00);
    chk("rst_payload", {awaddr, wdata, araddr}, 96'h0);
    chk("rst_results", {rd_data, rd_resp, wr_resp}, 36'h0);
    resetn = 1;
    @(negedge clk);

    // Basic write, slave ready at once
    cfg_bresp = 2'b00;
    drive_wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'h0, 2'b00, 1);
    @(negedge clk) wr_req = 0;
    chk("t1_valids_n1", {awvalid, wvalid}, 2'b11);
    chk("t1_ready_n1", wr_ready, 0);
    chk("t1_bready_n1", bready, 0);
    @(negedge clk);
    chk("t1_bready_n2", bready, 1);
    chk("t1_valids_n2", {awvalid, wvalid}, 2'b00);
    wait_wr(2, n);
    chk("t1_latency", n, 3);
    @(negedge clk);
    chk("t1_done_pulse", wr_done, 0);

    // Skewed W channel
    cfg_w_d = 3; cfg_bresp = 2'b10;
    drive_wr(32'h0000_0014, 32'hCAFE_F00D, 4'h3, 3'h2, 2'b10, 1);
    @(negedge clk) wr_req = 0;
    @(negedge clk);
    chk("t2_awvalid_dropped", awvalid, 0);
    chk("t2_wvalid_held", wvalid, 1);
    chk("t2_wdata_stable", {wdata, wstrb}, {32'hCAFE_F00D, 4'h3});
    chk("t2_no_early_bready", bready, 0);
    @(negedge clk);
    chk("t2_wvalid_held_n3", wvalid, 1);
    chk("t2_no_bready_n3", bready, 0);
    wait_wr(3, n);
    chk("t2_latency", n, 6);
    @(negedge clk);
    chk("t2_resp_held", wr_resp, 2'b10);
    cfg_w_d = 0;

    // Read with delayed AR and R
    cfg_ar_d = 3; cfg_r_d = 2; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    drive_rd(32'h0000_0020, 3'h0, 32'h1234_5678, 2'b00, 1);
    @(negedge clk) rd_req = 0;
    chk("t3_arvalid_n1", arvalid, 1);
    chk("t3_rd_ready_n1", rd_ready, 0);
    repeat (2) @(negedge clk);
    chk("t3_ar_stable", {arvalid, araddr}, {1'b1, 32'h0000_0020});
    chk("t3_no_early_rready", rready, 0);
    wait_rd(3, n);
    chk("t3_latency", n, 8);
    @(negedge clk);
    chk("t3_done_pulse", rd_done, 0);
    chk("t3_data_held", rd_data, 32'h1234_5678);

    // Concurrent write and read
    cfg_ar_d = 0; cfg_r_d = 0; cfg_rdata = 32'hA5A5_0001; cfg_rresp = 2'b01; cfg_bresp = 2'b11;
    drive_wr(32'h0000_0100, 32'h1111_2222, 4'h5, 3'h1, 2'b11, 1);
    drive_rd(32'h0000_0200, 3'h4, 32'hA5A5_0001, 2'b01, 1);
    @(negedge clk) begin wr_req = 0; rd_req = 0; end
    chk("t4_both_issued", {awvalid, wvalid, arvalid}, 3'b111);
    fork
      wait_wr(1, nw);
      wait_rd(1, nr);
    join
    chk("t4_wr_latency", nw, 3);
    chk("t4_rd_latency", nr, 3);

    // Back-to-back writes plus a request while busy
    cfg_bresp = 2'b00;
    @(negedge clk);
    base = aw_hs_cnt;
    drive_wr(32'h0000_0000, 32'h0000_00AA, 4'hF, 3'h0, 2'b00, 1);
    @(negedge clk) wr_req = 0;
    wait_wr(1, n);
    drive_wr(32'h0000_0004, 32'h0000_00BB, 4'hF, 3'h0, 2'b00, 1);
    @(negedge clk) wr_req = 0;
    chk("t5_second_aw", {awvalid, awaddr}, {1'b1, 32'h0000_0004});
    drive_wr(32'h0000_0008, 32'h0000_00CC, 4'hF, 3'h0, 2'b00, 0);
    @(negedge clk) wr_req = 0;
    wait_wr(2, n);
    chk("t5_second_latency", n, 3);
    repeat (4) @(negedge clk);
    chk("t5_aw_count", aw_hs_cnt - base, 2);

    // Stray B/R valids while idle
    stray = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_done", {wr_done, rd_done}, 2'b00);
      chk("t6_no_ready_out", {bready, rready}, 2'b00);
    end
    stray = 0;
    repeat (2) @(negedge clk);
    chk("t6_wr_resp_kept", wr_resp, 2'b00);
    chk("t6_rd_kept", {rd_data, rd_resp}, {32'hA5A5_0001, 2'b01});

    // Asynchronous reset mid-write
    cfg_aw_d = 20; cfg_w_d = 20;
    drive_wr(32'h0000_0030, 32'h7777_8888, 4'hF, 3'h0, 2'b00, 1);
    @(negedge clk) wr_req = 0;
    @(negedge clk);
    chk("t7_awvalid_before", awvalid, 1);
    #2 resetn = 0;
    #1;
    chk("t7_valids_cleared", {awvalid, wvalid, bready}, 3'b000);
    chk("t7_ready_restored", wr_ready, 1);
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    @(negedge clk);
    cfg_aw_d = 0; cfg_w_d = 0;
    @(negedge clk);
    #2 resetn = 1;
    @(negedge clk);
    cfg_bresp = 2'b01;
    drive_wr(32'h0000_0040, 32'h5A5A_5A5A, 4'hC, 3'h7, 2'b01, 1);
    @(negedge clk) wr_req = 0;
    wait_wr(1, n);
    chk("t7_fresh_latency", n, 3);
    chk("t7_fresh_resp", wr_resp, 2'b01);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
